// File: rtl/sabertooth_serial_rx.sv
// sabertooth_serial_rx
//
// 8N1 UART receiver plus simplified-serial motor command decoder. Bytes 1..127 set the
// motor 1 command (byte - 64), bytes 128..255 set the motor 2 command (byte - 192), and
// byte 0 stops both motors.
//
// Optional feature macro: SABERTOOTH_RX_WATCHDOG_EN
//   Defined   : a silence watchdog forces both commands to 0 after TIMEOUT_CLKS cycles
//               without a good byte, and raises timed_out until the next good byte.
//   Undefined : no watchdog; timed_out is tied low and commands hold indefinitely.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit (>= 8)
//   TIMEOUT_CLKS : watchdog silence limit in cycles (>= 2)
//
// Ports
//   CLOCK_50   in   clock
//   reset      in   asynchronous active-high reset
//   uart_in    in   serial line, asynchronous, idles high
//   byte_data  out  last byte received with a good stop bit
//   byte_valid out  one-cycle pulse when byte_data updates
//   frame_err  out  one-cycle pulse when a stop bit samples low
//   m1_cmd     out  signed motor 1 command
//   m2_cmd     out  signed motor 2 command
//   cmd_update out  one-cycle pulse when either command register is written
//   timed_out  out  high while the watchdog has expired

module sabertooth_serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_CLKS = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              uart_in,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  output logic              frame_err,
  output logic signed [6:0] m1_cmd,
  output logic signed [6:0] m2_cmd,
  output logic              cmd_update,
  output logic              timed_out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            cnt   <= HalfM1;
            state <= StStart;
          end
        end
        StStart: begin
          // Mid-start-bit check rejects short glitches.
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt     <= FullM1;
              bit_idx <= '0;
              state   <= StData;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StData: begin
          if (cnt == '0) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= FullM1;
            if (bit_idx == 3'd7) begin
              state <= StStop;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StStop: begin
          if (cnt == '0) begin
            if (rx_s) begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
              state      <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state     <= StWaitIdle;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StWaitIdle: begin
          // Hold off through a break so a low line never yields spurious frames.
          if (rx_s) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Offsets computed in 8-bit unsigned arithmetic; the low 7 bits are the signed command.
  logic [7:0] m1_diff;
  logic [7:0] m2_diff;
  logic       wd_expire;

  assign m1_diff = byte_data - 8'd64;
  assign m2_diff = byte_data - 8'd192;

`ifdef SABERTOOTH_RX_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CLKS);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CLKS - 1);

  logic [WdW-1:0] wd_cnt;

  // The byte_valid cycle counts as silent cycle 0, so the reload value is 1 and expiry
  // lands exactly TIMEOUT_CLKS cycles after the byte_valid pulse.
  assign wd_expire = !byte_valid && (wd_cnt == WdLast);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wd_cnt    <= WdMax;
      timed_out <= 1'b1;
    end else if (byte_valid) begin
      wd_cnt    <= WdW'(1);
      timed_out <= 1'b0;
    end else if (wd_cnt != WdMax) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m1_cmd     <= '0;
      m2_cmd     <= '0;
      cmd_update <= 1'b0;
    end else begin
      cmd_update <= 1'b0;
      if (byte_valid) begin
        cmd_update <= 1'b1;
        if (byte_data == 8'd0) begin
          m1_cmd <= '0;
          m2_cmd <= '0;
        end else if (!byte_data[7]) begin
          m1_cmd <= signed'(m1_diff[6:0]);
        end else begin
          m2_cmd <= signed'(m2_diff[6:0]);
        end
      end else if (wd_expire) begin
        m1_cmd     <= '0;
        m2_cmd     <= '0;
        cmd_update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sabertooth_serial_rx.sv
module tb_sabertooth_serial_rx;

  localparam int CPB = 16;
  localparam int TIMEOUT = 500;

`ifdef SABERTOOTH_RX_WATCHDOG_EN
  localparam int WD_ON = 1;
`else
  localparam int WD_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_in = 1'b1;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              frame_err;
  logic signed [6:0] m1_cmd;
  logic signed [6:0] m2_cmd;
  logic              cmd_update;
  logic              timed_out;

  sabertooth_serial_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .uart_in   (uart_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .m1_cmd    (m1_cmd),
    .m2_cmd    (m2_cmd),
    .cmd_update(cmd_update),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } byte_exp_t;

  typedef struct {
    int m1;
    int m2;
    int to;
    int delta;
  } cmd_exp_t;

  byte_exp_t byte_q[$];
  cmd_exp_t  cmd_q[$];
  int        n_tests = 0;
  int        n_fail = 0;
  int        cyc = 0;
  int        last_bv = 0;
  byte_exp_t be;
  cmd_exp_t  ce;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    byte_q.push_back('{err: 1'b0, data: b});
  endtask

  task automatic exp_ferr();
    byte_q.push_back('{err: 1'b1, data: 8'h00});
  endtask

  task automatic exp_cmd(input int m1, input int m2, input int to, input int delta);
    cmd_q.push_back('{m1: m1, m2: m2, to: to, delta: delta});
  endtask

  // Start bit, 8 data bits LSB first, then a stop bit (held low stop_low cycles if > 0).
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low > 0) begin
      uart_in = 1'b0;
      repeat (stop_low) @(negedge clk);
      uart_in = 1'b1;
    end else begin
      uart_in = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " byte_data"}, int'(byte_data), 0);
    check({tag, " byte_valid"}, int'(byte_valid), 0);
    check({tag, " frame_err"}, int'(frame_err), 0);
    check({tag, " m1_cmd"}, int'(m1_cmd), 0);
    check({tag, " m2_cmd"}, int'(m2_cmd), 0);
    check({tag, " cmd_update"}, int'(cmd_update), 0);
    check({tag, " timed_out"}, int'(timed_out), WD_ON);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && frame_err) begin
        n_tests++;
        n_fail++;
        $display("FAIL overlap: byte_valid and frame_err both 1, expected at most one");
      end
      if (byte_valid || frame_err) begin
        if (byte_valid) last_bv = cyc;
        if (byte_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte_event: got valid=%0d err=%0d data=%02h, expected none",
                   byte_valid, frame_err, byte_data);
        end else begin
          be = byte_q.pop_front();
          check("event_is_frame_err", int'(frame_err), int'(be.err));
          if (byte_valid) check("byte_data", int'(byte_data), int'(be.data));
        end
      end
      if (cmd_update) begin
        if (cmd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd_update: got m1=%0d m2=%0d, expected none",
                   m1_cmd, m2_cmd);
        end else begin
          ce = cmd_q.pop_front();
          check("m1_cmd", int'(m1_cmd), ce.m1);
          check("m2_cmd", int'(m2_cmd), ce.m2);
          check("timed_out", int'(timed_out), ce.to);
          check("cmd_latency", cyc - last_bv, ce.delta);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, upper m1 boundary.
    exp_byte(8'h7F); exp_cmd(63, 0, 0, 1);
    send_frame(8'h7F, 0);
    repeat (32) @(negedge clk);

    // Back-to-back frames, no idle gap.
    exp_byte(8'h80); exp_cmd(63, -64, 0, 1);
    exp_byte(8'hC0); exp_cmd(63, 0, 0, 1);
    exp_byte(8'h01); exp_cmd(-63, 0, 0, 1);
    send_frame(8'h80, 0);
    send_frame(8'hC0, 0);
    send_frame(8'h01, 0);
    repeat (32) @(negedge clk);

    // Stop bit held low: one frame error, commands untouched.
    exp_ferr();
    send_frame(8'h55, 40);
    repeat (32) @(negedge clk);
    check("m1_after_frame_err", int'(m1_cmd), -63);
    check("m2_after_frame_err", int'(m2_cmd), 0);
    exp_byte(8'h40); exp_cmd(0, 0, 0, 1);
    send_frame(8'h40, 0);
    repeat (32) @(negedge clk);

    // Short low glitch: no event; next frame proves the FSM is idle again.
    uart_in = 1'b0;
    repeat (4) @(negedge clk);
    uart_in = 1'b1;
    repeat (32) @(negedge clk);
    exp_byte(8'hFF); exp_cmd(0, 63, 0, 1);
    send_frame(8'hFF, 0);
    repeat (32) @(negedge clk);

    // Reset during data bit 3 of 0xAA.
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_in = 1'b0; repeat (CPB) @(negedge clk);
    uart_in = 1'b1; repeat (CPB) @(negedge clk);
    uart_in = 1'b0; repeat (CPB) @(negedge clk);
    uart_in = 1'b1; repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    uart_in = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_frame_reset");
    rst = 1'b0;
    repeat (32) @(negedge clk);

    exp_byte(8'hAA); exp_cmd(0, -22, 0, 1);
    send_frame(8'hAA, 0);
    repeat (32) @(negedge clk);
    exp_byte(8'h00); exp_cmd(0, 0, 0, 1);
    send_frame(8'h00, 0);
    repeat (32) @(negedge clk);

    // Last byte, then silence long enough for the watchdog.
    exp_byte(8'h60); exp_cmd(32, 0, 0, 1);
`ifdef SABERTOOTH_RX_WATCHDOG_EN
    exp_cmd(0, 0, 1, TIMEOUT);
`endif
    send_frame(8'h60, 0);
    repeat (600) @(negedge clk);
`ifdef SABERTOOTH_RX_WATCHDOG_EN
    check("silence_timed_out", int'(timed_out), 1);
    check("silence_m1", int'(m1_cmd), 0);
`else
    check("silence_timed_out", int'(timed_out), 0);
    check("silence_m1", int'(m1_cmd), 32);
`endif

    // Bounded drain, then every expected event must have been seen.
    for (int i = 0; i < 200; i++) begin
      if (byte_q.size() == 0 && cmd_q.size() == 0) break;
      @(negedge clk);
    end
    check("pending_byte_events", byte_q.size(), 0);
    check("pending_cmd_events", cmd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sabertooth_serial_rx.md
# sabertooth_serial_rx

UART receiver and command decoder for the simplified-serial motor protocol that the motor command path transmits on the GPIO UART line. It deserialises 8N1 frames from one input pin, checks framing, and decodes each byte into per-motor signed speed commands. It sits on the motor-controller side of the link and serves as a loopback checker for the transmit path in bench and hardware tests. An optional watchdog forces both commands to stop when the link goes silent.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit. 50 MHz / 9600 baud. Must be ≥ 8.
- `TIMEOUT_CLKS`, default 25_000_000: watchdog silence limit in cycles (0.5 s).
- `CLOCK_50`  input  1: the only clock.
- `reset`  input  1: asynchronous, active-high reset.
- `uart_in`  input  1: serial line. Asynchronous to `CLOCK_50`. Idles high.
- `byte_data`  output  8: last byte received with a good stop bit.
- `byte_valid`  output  1: one-cycle pulse when `byte_data` updates.
- `frame_err`  output  1: one-cycle pulse when the stop bit samples low.
- `m1_cmd`  output  7 signed: motor 1 command, range −63..+63.
- `m2_cmd`  output  7 signed: motor 2 command, range −64..+63.
- `cmd_update`  output  1: one-cycle pulse when either command register is written.
- `timed_out`  output  1: level. High while the watchdog has expired.

## Operation
**Synchronisation**
- `uart_in` passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- All logic below uses the synchronised signal `rx_s`.

**Receive FSM (states IDLE, START, DATA, STOP, WAIT_IDLE)**
- IDLE: on `rx_s` == 0, load the bit counter and go to START.
- START: wait `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
  - Sample is 0: go to DATA.
  - Sample is 1 (glitch): go to IDLE with no output.
- DATA: sample 8 bits, one every `CLKS_PER_BIT` cycles, LSB first, into the shift register. After bit 7, go to STOP.
- STOP: wait `CLKS_PER_BIT` cycles, then sample `rx_s`.
  - Sample is 1: load `byte_data`, pulse `byte_valid`, go to IDLE.
  - Sample is 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s` == 1, then go to IDLE. A break condition therefore never generates spurious frames.

**Decode**
- Decode runs on the `byte_valid` cycle. Registers update on the next edge, together with `cmd_update`.
- Byte 0: `m1_cmd` = 0 and `m2_cmd` = 0.
- Byte 1..127: `m1_cmd` = byte − 64. `m2_cmd` is unchanged.
- Byte 128..255: `m2_cmd` = byte − 192, computed in 8 bits and truncated to 7 bits signed. `m1_cmd` is unchanged.

**Width and range rules**
- Subtraction uses 8-bit unsigned arithmetic. The result always fits 7-bit two's complement.
- Byte 1 → −63. Byte 127 → +63. Byte 128 → −64. Byte 255 → +63.

## Timing
**Reset values**
- `byte_data` = 0, `byte_valid` = 0, `frame_err` = 0.
- `m1_cmd` = 0, `m2_cmd` = 0, `cmd_update` = 0.
- `timed_out` = 1 with the watchdog compiled in, 0 without it.
- FSM resets to IDLE.

**Latency**
- Falling edge on `uart_in` to the START sample: 2 synchroniser cycles + `CLKS_PER_BIT/2`.
- Stop-bit sample to `byte_valid`: `byte_valid` is registered, asserting the cycle after the sample.
- `cmd_update` and new command values follow `byte_valid` by 1 cycle.

**Boundary conditions**
- Reset mid-frame aborts immediately. The partial byte is lost and no pulse is emitted.
- A new start bit arriving in the same cycle the FSM enters IDLE is accepted normally. Back-to-back frames with a one-bit stop and no idle gap must receive correctly.
- `byte_valid` and `frame_err` are never high in the same cycle.

## Configuration
Macro `SABERTOOTH_RX_WATCHDOG_EN`.

**Defined**
- A counter clears on every `byte_valid` and increments otherwise, saturating at `TIMEOUT_CLKS`.
- When it reaches `TIMEOUT_CLKS`:
  - `timed_out` goes to 1.
  - `m1_cmd` and `m2_cmd` are forced to 0 the same cycle.
  - `cmd_update` pulses once.
- `timed_out` clears on the next `byte_valid`.

**Undefined**
- No counter is built.
- `timed_out` is tied to 0.
- Commands hold their last value indefinitely.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Send 0x7F with a good stop bit → `byte_valid` pulses with `byte_data` = 0x7F. One cycle later `m1_cmd` = +63, `m2_cmd` = 0, and `cmd_update` pulses.
- Send 0x80, then 0xC0, then 0x01 back-to-back with no idle gap → `m2_cmd` = −64, then `m2_cmd` = 0, then `m1_cmd` = −63. Exactly three `byte_valid` pulses.
- Send 0x55 with the stop bit held low for 40 cycles → one `frame_err` pulse, no `byte_valid`, commands unchanged. A following 0x40 decodes to `m1_cmd` = 0.
- Pulse `uart_in` low for 4 cycles → no `byte_valid` and no `frame_err`. FSM returns to IDLE.
- Assert `reset` at data bit 3 of 0xAA → all outputs return to reset values. A subsequent clean 0xAA gives `m2_cmd` = −22 (170 − 192).
- With `SABERTOOTH_RX_WATCHDOG_EN` and `TIMEOUT_CLKS` = 500:
  - Send 0x60 → `m1_cmd` = +32 and `timed_out` = 0.
  - Stay silent → exactly 500 cycles after the `byte_valid` pulse, `m1_cmd` = 0, `timed_out` = 1, and `cmd_update` pulses.
